// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: op codes, FSM states and flag bit positions.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_SHL1 = 4'h4,
        OP_SHR1 = 4'h5,
        OP_ROL1 = 4'h6,
        OP_ROR1 = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_NOR  = 4'hB,
        OP_NAND = 4'hC,
        OP_XNOR = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    // flags = {dz, v, n, z, c}
    localparam int unsigned FLAG_C  = 0;
    localparam int unsigned FLAG_Z  = 1;
    localparam int unsigned FLAG_N  = 2;
    localparam int unsigned FLAG_V  = 3;
    localparam int unsigned FLAG_DZ = 4;
    localparam int unsigned FLAG_W  = 5;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier and restoring divider, one bit per cycle for WIDTH cycles.
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    count;
    logic             is_div;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             ge;

    assign sum     = {1'b0, acc} + (quo[0] ? {1'b0, opnd} : '0);
    assign shifted = {acc, quo[WIDTH-1]};
    assign ge      = shifted >= {1'b0, opnd};
    assign trial   = shifted[WIDTH-1:0] - opnd;

    // lo/hi are the post-step values, so on the final step they are the finished result.
    always_comb begin
        lo = '0;
        hi = '0;
        if (is_div) begin
            hi = ge ? trial : shifted[WIDTH-1:0];
            lo = {quo[WIDTH-2:0], ge};
        end else begin
            hi = sum[WIDTH:1];
            lo = {sum[0], quo[WIDTH-1:1]};
        end
    end

    assign done = (count == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            is_div <= 1'b0;
            acc    <= '0;
            quo    <= '0;
            opnd   <= '0;
        end else if (start) begin
            count  <= CW'(WIDTH);
            is_div <= op;
            acc    <= '0;
            quo    <= op ? a : b;
            opnd   <= op ? b : a;
        end else if (count != '0) begin
            count <= count - CW'(1);
            acc   <= hi;
            quo   <= lo;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Valid/ready ALU: single-cycle ops complete in one cycle, MUL/DIV iterate for WIDTH cycles.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       op_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [4:0]       flags
);

    state_e state, state_nxt;
    op_e    op_dec;

    logic              accept;
    logic              start_iter;
    logic              iter_done;
    logic              iter_mul;
    logic [WIDTH-1:0]  iter_lo;
    logic [WIDTH-1:0]  iter_hi;
    logic [WIDTH:0]    add_sum;
    logic [WIDTH:0]    sub_diff;
    logic [WIDTH-1:0]  fast_lo;
    logic [WIDTH-1:0]  fast_hi;
    logic [FLAG_W-1:0] fast_flags;
    logic [FLAG_W-1:0] iter_flags;

    assign op_dec     = op_e'(op_sel);
    assign in_ready   = !rst && ((state == ST_IDLE) || (state == ST_DONE && out_ready));
    assign accept     = in_valid && in_ready;
    assign start_iter = accept && (op_dec == OP_MUL || (op_dec == OP_DIV && op_b != '0));
    assign out_valid  = (state == ST_DONE);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (start_iter),
        .op    (op_dec == OP_DIV),
        .a     (op_a),
        .b     (op_b),
        .done  (iter_done),
        .lo    (iter_lo),
        .hi    (iter_hi)
    );

    always_comb begin
        add_sum    = {1'b0, op_a} + {1'b0, op_b};
        sub_diff   = {1'b0, op_a} - {1'b0, op_b};
        fast_lo    = '0;
        fast_hi    = '0;
        fast_flags = '0;
        case (op_dec)
            OP_ADD: begin
                fast_lo            = add_sum[WIDTH-1:0];
                fast_flags[FLAG_C] = add_sum[WIDTH];
                fast_flags[FLAG_V] = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                     (add_sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                fast_lo            = sub_diff[WIDTH-1:0];
                fast_flags[FLAG_C] = sub_diff[WIDTH];
                fast_flags[FLAG_V] = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                                     (sub_diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_DIV: begin
                // Only the divide-by-zero case completes here; real divides iterate.
                if (op_b == '0) begin
                    fast_lo             = '1;
                    fast_hi             = op_a;
                    fast_flags[FLAG_DZ] = 1'b1;
                end
            end
            OP_SHL1: begin
                fast_lo            = {op_a[WIDTH-2:0], 1'b0};
                fast_flags[FLAG_C] = op_a[WIDTH-1];
            end
            OP_SHR1: begin
                fast_lo            = {1'b0, op_a[WIDTH-1:1]};
                fast_flags[FLAG_C] = op_a[0];
            end
            OP_ROL1: fast_lo = {op_a[WIDTH-2:0], op_a[WIDTH-1]};
            OP_ROR1: fast_lo = {op_a[0], op_a[WIDTH-1:1]};
            OP_AND:  fast_lo = op_a & op_b;
            OP_OR:   fast_lo = op_a | op_b;
            OP_XOR:  fast_lo = op_a ^ op_b;
            OP_NOR:  fast_lo = ~(op_a | op_b);
            OP_NAND: fast_lo = ~(op_a & op_b);
            OP_XNOR: fast_lo = ~(op_a ^ op_b);
            OP_GT:   fast_lo = WIDTH'(op_a > op_b);
            OP_EQ:   fast_lo = WIDTH'(op_a == op_b);
            default: ;
        endcase
        fast_flags[FLAG_N] = fast_lo[WIDTH-1];
        fast_flags[FLAG_Z] = (fast_lo == '0);
    end

    always_comb begin
        iter_flags         = '0;
        iter_flags[FLAG_C] = iter_mul && (iter_hi != '0);
        iter_flags[FLAG_N] = iter_lo[WIDTH-1];
        iter_flags[FLAG_Z] = (iter_lo == '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = start_iter ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                if (iter_done) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (accept) state_nxt = start_iter ? ST_BUSY : ST_DONE;
                    else        state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
            iter_mul  <= 1'b0;
        end else begin
            if (accept) iter_mul <= (op_dec == OP_MUL);
            if (state == ST_BUSY && iter_done) begin
                result    <= iter_lo;
                result_hi <= iter_hi;
                flags     <= iter_flags;
            end else if (accept && !start_iter) begin
                result    <= fast_lo;
                result_hi <= fast_hi;
                flags     <= fast_flags;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu (WIDTH=8) with an expected-result scoreboard.
module tb_multicycle_alu;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [3:0] op_sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic [4:0] flags;

    typedef struct {
        string      tag;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [4:0] fl;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    multicycle_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_out(input int k);
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_latency"}, 32'(k), 32'(e.lat));
        check({e.tag, "_out_valid"}, 32'(out_valid), 32'(1));
        check({e.tag, "_result"}, 32'(result), 32'(e.lo));
        check({e.tag, "_result_hi"}, 32'(result_hi), 32'(e.hi));
        check({e.tag, "_flags"}, 32'(flags), 32'(e.fl));
    endtask

    // Issue one request with out_ready=1 and wait (bounded) for its result.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] op, input logic [7:0] elo, input logic [7:0] ehi,
                          input logic [4:0] efl, input int lat);
        int k;
        @(negedge clk);
        op_a = a; op_b = b; op_sel = op; in_valid = 1'b1;
        sb.push_back('{tag, elo, ehi, efl, lat});
        check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
        @(negedge clk);
        in_valid = 1'b0;
        k = 1;
        while (out_valid !== 1'b1 && k < 40) begin
            check({tag, "_busy_in_ready"}, 32'(in_ready), 32'(0));
            op_a = 8'($urandom); op_b = 8'($urandom); op_sel = 4'($urandom);
            @(negedge clk);
            k++;
        end
        compare_out(k);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op_a = '0; op_b = '0; op_sel = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_result", 32'(result), 32'(0));
        check("rst_result_hi", 32'(result_hi), 32'(0));
        check("rst_flags", 32'(flags), 32'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'(1));

        run_op("add_f0_20",  8'hF0, 8'h20, OP_ADD,  8'h10, 8'h00, 5'b00001, 1);
        run_op("add_80_80",  8'h80, 8'h80, OP_ADD,  8'h00, 8'h00, 5'b01011, 1);
        run_op("sub_05_07",  8'h05, 8'h07, OP_SUB,  8'hFE, 8'h00, 5'b00101, 1);
        run_op("sub_80_01",  8'h80, 8'h01, OP_SUB,  8'h7F, 8'h00, 5'b01000, 1);
        run_op("sub_33_33",  8'h33, 8'h33, OP_SUB,  8'h00, 8'h00, 5'b00010, 1);
        run_op("mul_12_34",  8'h12, 8'h34, OP_MUL,  8'hA8, 8'h03, 5'b00101, 9);
        run_op("mul_0f_0f",  8'h0F, 8'h0F, OP_MUL,  8'hE1, 8'h00, 5'b00100, 9);
        run_op("div_200_7",  8'd200, 8'd7, OP_DIV,  8'd28, 8'd4,  5'b00000, 9);
        run_op("div_5_0",    8'h05, 8'h00, OP_DIV,  8'hFF, 8'h05, 5'b10100, 1);
        run_op("div_7_200",  8'd7, 8'd200, OP_DIV,  8'h00, 8'd7,  5'b00010, 9);
        run_op("shl1_81",    8'h81, 8'h00, OP_SHL1, 8'h02, 8'h00, 5'b00001, 1);
        run_op("shr1_81",    8'h81, 8'h00, OP_SHR1, 8'h40, 8'h00, 5'b00001, 1);
        run_op("rol1_81",    8'h81, 8'h00, OP_ROL1, 8'h03, 8'h00, 5'b00000, 1);
        run_op("ror1_81",    8'h81, 8'h00, OP_ROR1, 8'hC0, 8'h00, 5'b00100, 1);
        run_op("or_0f_f0",   8'h0F, 8'hF0, OP_OR,   8'hFF, 8'h00, 5'b00100, 1);
        run_op("nor_0f_f0",  8'h0F, 8'hF0, OP_NOR,  8'h00, 8'h00, 5'b00010, 1);
        run_op("nand_ff_ff", 8'hFF, 8'hFF, OP_NAND, 8'h00, 8'h00, 5'b00010, 1);
        run_op("xnor_a5_a5", 8'hA5, 8'hA5, OP_XNOR, 8'hFF, 8'h00, 5'b00100, 1);
        run_op("gt_05_03",   8'h05, 8'h03, OP_GT,   8'h01, 8'h00, 5'b00000, 1);
        run_op("gt_03_05",   8'h03, 8'h05, OP_GT,   8'h00, 8'h00, 5'b00010, 1);
        run_op("eq_07_07",   8'h07, 8'h07, OP_EQ,   8'h01, 8'h00, 5'b00000, 1);

        // Backpressure: result must hold for 5 cycles and requests must be refused.
        @(negedge clk);
        out_ready = 1'b0;
        op_a = 8'hCC; op_b = 8'hAA; op_sel = OP_AND; in_valid = 1'b1;
        sb.push_back('{"hold_and", 8'h88, 8'h00, 5'b00100, 1});
        check("hold_and_in_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        in_valid = 1'b0;
        compare_out(1);
        for (int i = 0; i < 5; i++) begin
            op_a = 8'($urandom); op_b = 8'($urandom); op_sel = OP_ADD; in_valid = 1'b1;
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'(1));
            check("hold_in_ready", 32'(in_ready), 32'(0));
            check("hold_result", 32'(result), 32'(8'h88));
            check("hold_result_hi", 32'(result_hi), 32'(8'h00));
            check("hold_flags", 32'(flags), 32'(5'b00100));
        end
        out_ready = 1'b1;
        op_a = 8'hF0; op_b = 8'h3C; op_sel = OP_XOR; in_valid = 1'b1;
        sb.push_back('{"b2b_xor", 8'hCC, 8'h00, 5'b00100, 1});
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        in_valid = 1'b0;
        compare_out(1);

        // Reset in the 4th BUSY cycle of a MUL aborts it.
        @(negedge clk);
        op_a = 8'h12; op_b = 8'h34; op_sel = OP_MUL; in_valid = 1'b1;
        check("abort_mul_in_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_in_ready", 32'(in_ready), 32'(0));
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'(0));
        check("abort_in_ready", 32'(in_ready), 32'(0));
        check("abort_result", 32'(result), 32'(0));
        check("abort_result_hi", 32'(result_hi), 32'(0));
        check("abort_flags", 32'(flags), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_release_in_ready", 32'(in_ready), 32'(1));
        check("abort_release_out_valid", 32'(out_valid), 32'(0));
        run_op("add_1_1", 8'h01, 8'h01, OP_ADD, 8'h02, 8'h00, 5'b00000, 1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
